// File: rtl/load_store_unit_if.sv
// Core/memory handshake bundle for load_store_unit.
// master: the load/store unit itself (accepts core requests, drives the memory port).
// slave : the environment around it (execute stage and data memory).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store initiator for the data memory.
// Issues word-aligned accesses with byte enables, aligns and extends read data,
// and guards every memory transaction with a timeout.
// Build option LSU_SPLIT_EN: when defined, word-crossing accesses are split into
// two transactions; when undefined they are trapped with resp_err.
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE0 | strobe first (or only) memory transaction
// WAIT0  | wait for ack of first transaction, timeout-guarded
// ISSUE1 | strobe second transaction of a word-crossing access
// WAIT1  | wait for ack of second transaction, timeout-guarded
// RESP   | one-cycle response to the core
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata0_q, rdata0_d;
    logic [31:0]        rdata1_q, rdata1_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               req_ready_c, resp_valid_c, resp_err_c;
    logic [31:0]        resp_rdata_c;
    logic               mem_req_c, mem_we_c;
    logic [31:0]        mem_addr_c, mem_wdata_c;
    logic [3:0]         mem_be_c;

    function automatic logic [2:0] access_size(input logic [1:0] f);
        case (f)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] f);
        logic [2:0] last;
        last = {1'b0, off} + access_size(f);
        crosses_word = (last > 3'd4);
    endfunction

    function automatic logic is_illegal(input logic w, input logic [2:0] f);
        is_illegal = (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || (w && f[2]);
    endfunction

    logic [1:0]  off_w;
    logic [3:0]  lane_mask_w;
    logic [7:0]  mask_w;
    logic [63:0] wdata64_w;
    logic [31:0] rword_w;
    logic [31:0] load_ext_w;
    logic        cross_w;
    logic        tmo_w;

    // Lane mask, shifted data and extended load result from the latched request
    always_comb begin
        off_w = addr_q[1:0];
        case (funct3_q[1:0])
            2'b00:   lane_mask_w = 4'b0001;
            2'b01:   lane_mask_w = 4'b0011;
            default: lane_mask_w = 4'b1111;
        endcase
        mask_w    = {4'h0, lane_mask_w} << off_w;
        wdata64_w = {32'h0, wdata_q} << {off_w, 3'b000};
        rword_w   = 32'({rdata1_q, rdata0_q} >> {off_w, 3'b000});
        case (funct3_q)
            3'b000:  load_ext_w = {{24{rword_w[7]}}, rword_w[7:0]};
            3'b001:  load_ext_w = {{16{rword_w[15]}}, rword_w[15:0]};
            3'b100:  load_ext_w = {24'h0, rword_w[7:0]};
            3'b101:  load_ext_w = {16'h0, rword_w[15:0]};
            default: load_ext_w = rword_w;
        endcase
        cross_w = crosses_word(off_w, funct3_q[1:0]);
        tmo_w   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        resp_err_c   = 1'b0;
        resp_rdata_c = '0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_be_c     = '0;
        mem_wdata_c  = '0;

        case (state_q)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata0_d = '0;
                    rdata1_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    if (is_illegal(bus.req_write, bus.req_funct3)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
`ifdef LSU_SPLIT_EN
                    end else begin
                        state_d = S_ISSUE0;
                    end
`else
                    end else if (crosses_word(bus.req_addr[1:0], bus.req_funct3[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE0;
                    end
`endif
                end
            end
            S_ISSUE0: begin
                mem_req_c   = 1'b1;
                mem_we_c    = write_q;
                mem_addr_c  = {addr_q[31:2], 2'b00};
                mem_be_c    = mask_w[3:0];
                mem_wdata_c = wdata64_w[31:0];
                cnt_d       = '0;
                state_d     = S_WAIT0;
            end
            S_WAIT0: begin
                if (bus.mem_ack) begin
                    rdata0_d = bus.mem_rdata;
                    state_d  = cross_w ? S_ISSUE1 : S_RESP;
                end else if (tmo_w) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE1: begin
                mem_req_c   = 1'b1;
                mem_we_c    = write_q;
                mem_addr_c  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_be_c    = mask_w[7:4];
                mem_wdata_c = wdata64_w[63:32];
                cnt_d       = '0;
                state_d     = S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.mem_ack) begin
                    rdata1_d = bus.mem_rdata;
                    state_d  = S_RESP;
                end else if (tmo_w) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                resp_valid_c = 1'b1;
                resp_err_c   = err_q;
                resp_rdata_c = (err_q || write_q) ? 32'h0 : load_ext_w;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are held quiet for the whole time reset is asserted,
        // not only after the first reset edge has been seen.
        if (!rst_n) begin
            req_ready_c  = 1'b0;
            resp_valid_c = 1'b0;
            resp_err_c   = 1'b0;
            resp_rdata_c = '0;
            mem_req_c    = 1'b0;
            mem_we_c     = 1'b0;
            mem_addr_c   = '0;
            mem_be_c     = '0;
            mem_wdata_c  = '0;
        end
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_err   = resp_err_c;
    assign bus.resp_rdata = resp_rdata_c;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_be     = mem_be_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule
